// File: rtl/riscv_lsu.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_lsu
//  Description : Load/store unit between the core datapath and a
//                variable-latency data memory port. Handles byte, halfword,
//                word and (XLEN=64) doubleword accesses with sign/zero
//                extension on loads and byte-enable generation on stores.
//                Core side uses busy/done; memory side uses req/gnt/rvalid.
//  Revision    : 1.0 - initial release
// ============================================================================
module riscv_lsu #(
    parameter int XLEN      = 32,
    parameter bit MEM_ALIGN = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_i,
    input  logic              is_store_i,
    input  logic [2:0]        funct3_i,
    input  logic [XLEN-1:0]   addr_i,
    input  logic [XLEN-1:0]   wdata_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [XLEN-1:0]   rdata_o,
    output logic              misalign_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [XLEN-1:0]   mem_addr_o,
    output logic [XLEN/8-1:0] mem_be_o,
    output logic [XLEN-1:0]   mem_wdata_o,
    input  logic              mem_gnt_i,
    input  logic              mem_rvalid_i,
    input  logic [XLEN-1:0]   mem_rdata_i
);

    localparam int c_nb   = XLEN / 8;
    localparam int c_offw = $clog2(c_nb);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_req  = 2'd1;
    localparam logic [1:0] c_st_wait = 2'd2;
    localparam logic [1:0] c_st_done = 2'd3;

    logic [1:0]        r_state;
    logic [1:0]        w_state_next;
    logic              r_store;
    logic [2:0]        r_funct3;
    logic [XLEN-1:0]   r_addr;
    logic [XLEN-1:0]   r_wdata;
    logic [XLEN-1:0]   r_rdata;
    logic              r_fault;

    logic [c_offw-1:0] w_in_off;
    logic [c_offw-1:0] w_off;
    logic              w_accept;
    logic              w_fault;
    logic [c_nb-1:0]   w_size_mask;
    logic [XLEN-1:0]   w_rshift;
    logic [XLEN-1:0]   w_word_sext;
    logic [XLEN-1:0]   w_word_zext;
    logic [XLEN-1:0]   w_ext;

    assign w_in_off = addr_i[c_offw-1:0];
    assign w_off    = r_addr[c_offw-1:0];
    assign w_accept = (r_state == c_st_idle) && valid_i;

    // Classify the incoming access: unsupported encodings and lane misalignment fault
    always_comb begin
        w_fault = 1'b0;
        case (funct3_i[1:0])
            2'b01:   if (w_in_off[0])            w_fault = 1'b1;
            2'b10:   if (w_in_off[1:0] != 2'b00) w_fault = 1'b1;
            2'b11:   if ((XLEN == 32) || (w_in_off != '0)) w_fault = 1'b1;
            default: w_fault = 1'b0;
        endcase
        if (funct3_i == 3'b111)                   w_fault = 1'b1;
        if ((funct3_i == 3'b110) && (XLEN == 32)) w_fault = 1'b1;
        if (is_store_i && funct3_i[2])            w_fault = 1'b1;
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= c_st_idle;
        else       r_state <= w_state_next;
    end

    // Next-state logic; faults skip the memory and complete immediately
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_idle: if (valid_i)      w_state_next = w_fault ? c_st_done : c_st_req;
            c_st_req:  if (mem_gnt_i)    w_state_next = r_store ? c_st_done : c_st_wait;
            c_st_wait: if (mem_rvalid_i) w_state_next = c_st_done;
            default:                     w_state_next = c_st_idle;
        endcase
    end

    // Capture the access attributes when a new request is accepted
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_store  <= 1'b0;
            r_funct3 <= 3'b000;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_fault  <= 1'b0;
        end else if (w_accept) begin
            r_store  <= is_store_i;
            r_funct3 <= funct3_i;
            r_addr   <= addr_i;
            r_wdata  <= wdata_i;
            r_fault  <= w_fault;
        end
    end

    // Lane-align the returned data; the word extensions only differ when XLEN is 64
    assign w_rshift = mem_rdata_i >> {w_off, 3'b000};

    generate
        if (XLEN == 64) begin : g_word64
            assign w_word_sext = {{32{w_rshift[31]}}, w_rshift[31:0]};
            assign w_word_zext = {32'b0, w_rshift[31:0]};
        end else begin : g_word32
            assign w_word_sext = w_rshift;
            assign w_word_zext = w_rshift;
        end
    endgenerate

    // Sign- or zero-extend the aligned load data according to the load type
    always_comb begin
        w_ext = w_rshift;
        case (r_funct3)
            3'b000:  w_ext = {{(XLEN-8){w_rshift[7]}},   w_rshift[7:0]};
            3'b001:  w_ext = {{(XLEN-16){w_rshift[15]}}, w_rshift[15:0]};
            3'b010:  w_ext = w_word_sext;
            3'b100:  w_ext = {{(XLEN-8){1'b0}},  w_rshift[7:0]};
            3'b101:  w_ext = {{(XLEN-16){1'b0}}, w_rshift[15:0]};
            3'b110:  w_ext = w_word_zext;
            default: w_ext = w_rshift;
        endcase
    end

    // Load result register; only a completing load updates it
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                                      r_rdata <= '0;
        else if ((r_state == c_st_wait) && mem_rvalid_i) r_rdata <= w_ext;
    end

    // Byte-enable pattern for the access size before lane shifting
    always_comb begin
        w_size_mask = '0;
        case (r_funct3[1:0])
            2'b00:   w_size_mask = c_nb'(8'h01);
            2'b01:   w_size_mask = c_nb'(8'h03);
            2'b10:   w_size_mask = c_nb'(8'h0F);
            default: w_size_mask = c_nb'(8'hFF);
        endcase
    end

    generate
        if (MEM_ALIGN) begin : g_align
            assign mem_addr_o = {r_addr[XLEN-1:c_offw], {c_offw{1'b0}}};
        end else begin : g_no_align
            assign mem_addr_o = r_addr;
        end
    endgenerate

    assign mem_wdata_o = r_wdata << {w_off, 3'b000};
    assign rdata_o     = r_rdata;

    // State-decoded handshake outputs; request qualifiers are zero outside REQ
    always_comb begin
        busy_o     = (r_state != c_st_idle);
        done_o     = (r_state == c_st_done);
        misalign_o = (r_state == c_st_done) && r_fault;
        mem_req_o  = (r_state == c_st_req);
        mem_we_o   = (r_state == c_st_req) && r_store;
        mem_be_o   = (r_state == c_st_req) ? (w_size_mask << w_off) : '0;
    end

endmodule
`default_nettype wire
